// File: rtl/vga_layer_compositor.sv
// Two-stage pixel compositor: a tile-map background overlaid with prioritised,
// per-pixel transparent sprites. Sprite positions are shadowed per frame and overlaps are latched per frame.
module vga_layer_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_SIZE = 42,
    parameter int BLOCK_WIDTH = 40,
    parameter int MAP_ROWS    = 12,
    parameter int MAP_COLS    = 17,
    parameter int COORD_W     = 10,
    parameter int LW          = $clog2(SPRITE_SIZE),
    parameter int BDR         = 0,
    parameter int SKY         = 1,
    parameter int BLK         = 2,
    parameter int GND         = 3,
    parameter int TKN         = 4,
    localparam int TA_W       = $clog2(MAP_ROWS * MAP_COLS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pix_valid,
    input  logic [COORD_W-1:0]             pix_row,
    input  logic [COORD_W-1:0]             pix_col,
    input  logic                           frame_start,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_x_in,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_y_in,
    input  logic [NUM_SPRITES-1:0]         spr_en_in,
    output logic [TA_W-1:0]                tile_addr,
    input  logic [7:0]                     tile_code,
    output logic [NUM_SPRITES*LW-1:0]      spr_lx,
    output logic [NUM_SPRITES*LW-1:0]      spr_ly,
    input  logic [NUM_SPRITES*13-1:0]      spr_pix,
    output logic                           out_valid,
    output logic [3:0]                     red,
    output logic [3:0]                     green,
    output logic [3:0]                     blue,
    output logic [NUM_SPRITES-1:0]         collision
);

    localparam int PIX_W = 13;
    localparam logic [COORD_W-1:0] BW_C   = COORD_W'(BLOCK_WIDTH);
    localparam logic [COORD_W-1:0] ROWS_C = COORD_W'(MAP_ROWS);
    localparam logic [COORD_W-1:0] COLS_C = COORD_W'(MAP_COLS);
    localparam logic [COORD_W:0]   SIZE_C = (COORD_W + 1)'(SPRITE_SIZE);
    localparam logic [TA_W-1:0]    MCOL_C = TA_W'(MAP_COLS);
    localparam logic [7:0] BDR_C = 8'(BDR);
    localparam logic [7:0] SKY_C = 8'(SKY);
    localparam logic [7:0] BLK_C = 8'(BLK);
    localparam logic [7:0] GND_C = 8'(GND);
    localparam logic [7:0] TKN_C = 8'(TKN);

    function automatic logic [11:0] bg_rgb(input logic [7:0] code, input logic oob);
        logic [11:0] c;
        c = 12'h000;
        if (!oob) begin
            case (code)
                GND_C:   c = 12'h0F2;
                SKY_C:   c = 12'h09F;
                BLK_C:   c = 12'h843;
                TKN_C:   c = 12'h09F;
                BDR_C:   c = 12'h000;
                default: c = 12'h000;
            endcase
        end
        return c;
    endfunction

    function automatic int unsigned count_ones(input logic [NUM_SPRITES-1:0] v);
        int unsigned n;
        n = 0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            n += int'(v[k]);
        end
        return n;
    endfunction

    // Frame-shadowed sprite state
    logic [NUM_SPRITES*COORD_W-1:0] act_x_q, act_x_d;
    logic [NUM_SPRITES*COORD_W-1:0] act_y_q, act_y_d;
    logic [NUM_SPRITES-1:0]         act_en_q, act_en_d;

    logic [COORD_W-1:0]        trow, tcol;
    logic                      vld_p1_q, vld_p1_d;
    logic                      oob_p1_q, oob_p1_d;
    logic [NUM_SPRITES-1:0]    hit_p1_q, hit_p1_d;
    logic [TA_W-1:0]           tile_addr_q, tile_addr_d;
    logic [NUM_SPRITES*LW-1:0] spr_lx_q, spr_lx_d;
    logic [NUM_SPRITES*LW-1:0] spr_ly_q, spr_ly_d;

    logic [NUM_SPRITES-1:0] vis, overlap;
    logic [11:0]            rgb_sel;
    logic                   vld_p2_q, vld_p2_d;
    logic [11:0]            rgb_p2_q, rgb_p2_d;
    logic [NUM_SPRITES-1:0] pending_q, pending_d;
    logic [NUM_SPRITES-1:0] collision_q, collision_d;

    always_comb begin
        act_x_d  = frame_start ? spr_x_in  : act_x_q;
        act_y_d  = frame_start ? spr_y_in  : act_y_q;
        act_en_d = frame_start ? spr_en_in : act_en_q;
    end

    // Stage 1: tile address, sprite hit tests and sprite-local coordinates
    always_comb begin
        trow        = pix_row / BW_C;
        tcol        = pix_col / BW_C;
        vld_p1_d    = pix_valid;
        oob_p1_d    = (trow >= ROWS_C) || (tcol >= COLS_C);
        tile_addr_d = oob_p1_d ? '0 : TA_W'(trow) * MCOL_C + TA_W'(tcol);
        hit_p1_d    = '0;
        spr_lx_d    = '0;
        spr_ly_d    = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            // One extra bit keeps x+SIZE from wrapping back onto column/row 0.
            hit_p1_d[i] = act_en_q[i]
                && ({1'b0, pix_col} >= {1'b0, act_x_q[i*COORD_W +: COORD_W]})
                && ({1'b0, pix_col} <  ({1'b0, act_x_q[i*COORD_W +: COORD_W]} + SIZE_C))
                && ({1'b0, pix_row} >= {1'b0, act_y_q[i*COORD_W +: COORD_W]})
                && ({1'b0, pix_row} <  ({1'b0, act_y_q[i*COORD_W +: COORD_W]} + SIZE_C));
            spr_lx_d[i*LW +: LW] = LW'(pix_col - act_x_q[i*COORD_W +: COORD_W]);
            spr_ly_d[i*LW +: LW] = LW'(pix_row - act_y_q[i*COORD_W +: COORD_W]);
        end
    end

    // Stage 2: priority select, background palette, collision accumulation
    always_comb begin
        vis     = '0;
        rgb_sel = 12'h000;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            vis[i] = hit_p1_q[i] & spr_pix[i*PIX_W + 12];
        end
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (vis[i]) rgb_sel = spr_pix[i*PIX_W +: 12];
        end
        if (vis == '0) rgb_sel = bg_rgb(tile_code, oob_p1_q);
        vld_p2_d = vld_p1_q;
        rgb_p2_d = vld_p1_q ? rgb_sel : 12'h000;
        overlap  = (vld_p1_q && count_ones(vis) >= 2) ? vis : '0;
        if (frame_start) begin
            collision_d = pending_q;
            pending_d   = overlap;
        end else begin
            collision_d = collision_q;
            pending_d   = pending_q | overlap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x_q     <= '0;
            act_y_q     <= '0;
            act_en_q    <= '0;
            vld_p1_q    <= 1'b0;
            oob_p1_q    <= 1'b0;
            hit_p1_q    <= '0;
            tile_addr_q <= '0;
            spr_lx_q    <= '0;
            spr_ly_q    <= '0;
            vld_p2_q    <= 1'b0;
            rgb_p2_q    <= '0;
            pending_q   <= '0;
            collision_q <= '0;
        end else begin
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            act_en_q    <= act_en_d;
            vld_p1_q    <= vld_p1_d;
            oob_p1_q    <= oob_p1_d;
            hit_p1_q    <= hit_p1_d;
            tile_addr_q <= tile_addr_d;
            spr_lx_q    <= spr_lx_d;
            spr_ly_q    <= spr_ly_d;
            vld_p2_q    <= vld_p2_d;
            rgb_p2_q    <= rgb_p2_d;
            pending_q   <= pending_d;
            collision_q <= collision_d;
        end
    end

    assign tile_addr = tile_addr_q;
    assign spr_lx    = spr_lx_q;
    assign spr_ly    = spr_ly_q;
    assign out_valid = vld_p2_q;
    assign red       = rgb_p2_q[11:8];
    assign green     = rgb_p2_q[7:4];
    assign blue      = rgb_p2_q[3:0];
    assign collision = collision_q;

endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
- Pipelined, registered pixel compositor for the VGA path. It generalises the combinational tile/character drawer to NUM_SPRITES prioritised sprites with per-pixel transparency.
- Positions are shadowed per frame so sprites never tear mid-frame.
- Sprite-to-sprite overlap is detected per frame as a collision flag.
- Sits between the VGA timing generator (row/col stream) and the DAC pins. Tile-map RAM and sprite ROMs are external.

Parameters:
NUM_SPRITES, 4, number of sprite layers; index 0 has highest priority
SPRITE_SIZE, 42, sprite width and height in pixels (square)
BLOCK_WIDTH, 40, tile edge in pixels
MAP_ROWS, 12, tile-map rows
MAP_COLS, 17, tile-map columns
COORD_W, 10, pixel coordinate width
LW, $clog2(SPRITE_SIZE), sprite-local coordinate width
BDR, 0, tile code: border
SKY, 1, tile code: sky
BLK, 2, tile code: brick
GND, 3, tile code: ground
TKN, 4, tile code: token

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pix_valid  in  1  row/col carry a visible pixel this cycle
pix_row  in  COORD_W  pixel row
pix_col  in  COORD_W  pixel column
frame_start  in  1  one-cycle pulse before the first pixel of a frame
spr_x_in  in  NUM_SPRITES*COORD_W  sprite left edges; sprite i at [i*COORD_W +: COORD_W]
spr_y_in  in  NUM_SPRITES*COORD_W  sprite top edges
spr_en_in  in  NUM_SPRITES  sprite enables
tile_addr  out  $clog2(MAP_ROWS*MAP_COLS)  tile-map read address (registered)
tile_code  in  8  tile-map data; combinational from tile_addr
spr_lx  out  NUM_SPRITES*LW  sprite-local x for each sprite ROM (registered)
spr_ly  out  NUM_SPRITES*LW  sprite-local y for each sprite ROM (registered)
spr_pix  in  NUM_SPRITES*13  per sprite {opaque, r[3:0], g[3:0], b[3:0]}; combinational from spr_lx/ly
out_valid  out  1  red/green/blue carry a composited pixel
red  out  4  red output
green  out  4  green output
blue  out  4  blue output
collision  out  NUM_SPRITES  per-sprite overlap flags for the previous frame

Behaviour:
- Reset (rst_n low, asynchronous):
  - Cleared to 0: red, green, blue, out_valid, collision, tile_addr, spr_lx, spr_ly.
  - Cleared to 0: active sprite positions, active enables, pending-collision bits and all pipeline valids.
- Shadowing:
  - On a clk edge with frame_start=1, active positions and enables are loaded from spr_*_in.
  - A pixel presented in the same cycle as frame_start uses the old active values.
  - spr_*_in changes at any other time have no effect.
- Stage 1 (edge after pix_valid):
  - v1 <= pix_valid.
  - tile_addr <= (row/BLOCK_WIDTH)*MAP_COLS + col/BLOCK_WIDTH.
  - oob1 <= 1 if row/BLOCK_WIDTH >= MAP_ROWS or col/BLOCK_WIDTH >= MAP_COLS; tile_addr is then 0.
  - hit1[i] <= en[i] && x[i] <= col < x[i]+SPRITE_SIZE && y[i] <= row < y[i]+SPRITE_SIZE. The range is half-open; compute sums at COORD_W+1 bits so there is no wrap.
  - spr_lx[i] <= col-x[i] and spr_ly[i] <= row-y[i], truncated to LW bits. These values are don't-care when not hit.
- Stage 2 (next edge; samples tile_code and spr_pix):
  - vis[i] = hit1[i] && opaque[i].
  - Winner is the lowest i with vis[i]; output pixel is that sprite's rgb.
  - With no winner, the background palette applies:
    - GND = 0/15/2
    - SKY = 0/9/15
    - BLK = 8/4/3
    - TKN = 0/9/15
    - BDR, any other code, or oob1 = 0/0/0
  - out_valid <= v1, giving 2-cycle latency.
  - When v1=0, red/green/blue <= 0.
- Throughput is one pixel per clock. There is no stall.
- Collision:
  - When v1 && popcount(vis) >= 2, pending[i] |= vis[i].
  - On frame_start: collision <= pending, and pending <= that cycle's new overlap bits, or 0 if none. Same-cycle overlap is never lost.
  - collision is held constant between frame_start pulses.
- A disabled sprite never hits, never draws and never sets collision.
- A sprite partly off the right/bottom edge draws only its on-screen pixels. No wrap-around to column/row 0.

Test Plan:
- Reset mid-stream: pix_valid=1 with a sprite visible, pulse rst_n low -> out_valid, rgb and collision are 0 immediately (asynchronous). The first valid output appears 2 cycles after pix_valid resumes.
- Background: no sprites, map code GND at tile (3,2), pixel row=125 col=85 -> tile_addr=53 one cycle later; rgb=0/15/2 with out_valid exactly 2 cycles after input. Pixel row=480 -> rgb=0/0/0.
- Sprite edges: sprite0 at x=100,y=50 en, ROM all opaque 15/0/0 -> col 100..141 row 50 give red. Col 142 and col 99 give background. spr_lx=41 at col 141.
- Priority/transparency: sprites 0 and 1 overlap, sprite0 transparent at local (5,5) -> pixel shows sprite1 rgb. Where both are opaque, sprite0 wins.
- Collision latch: overlap during frame N -> collision=4'b0011 after the frame_start that begins N+1; a frame with no overlap -> 0 after the next frame_start.
- Shadowing: change spr_x_in mid-frame from 100 to 200 -> drawn position stays 100 until after the next frame_start. A pixel in the same cycle as frame_start still uses 100.
